tg_run_ctrl: RTL

TG_RUN_CTRL -- requirements
Module: tg_run_ctrl

---
 rtl/tg_run_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tg_run_ctrl.sv
// Traffic-generator sweep sequencer: launches generators at stepped loads and reports per-step cycle counts.
// Optional step watchdog compiled in with `define TG_RUN_CTRL_TIMEOUT_EN.
module tg_run_ctrl #(
    parameter int unsigned NUM_TG     = 4,
    parameter int unsigned LOAD_WIDTH = 16,
    parameter int unsigned TICK_WIDTH = 256,
    parameter int unsigned CYC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [LOAD_WIDTH-1:0] load_start,
    input  logic [LOAD_WIDTH-1:0] load_step,
    input  logic [LOAD_WIDTH-1:0] load_max,
    input  logic [15:0]           drain_cycles,
    input  logic [CYC_WIDTH-1:0]  timeout_cycles,
    input  logic [NUM_TG-1:0]     tg_done,
    output logic                  tg_start,
    output logic [LOAD_WIDTH-1:0] tg_load,
    output logic [TICK_WIDTH-1:0] ticks,
    output logic                  busy,
    output logic                  step_valid,
    output logic [LOAD_WIDTH-1:0] step_load,
    output logic [CYC_WIDTH-1:0]  step_cycles,
    output logic                  sweep_done,
    output logic                  error
);

    localparam int unsigned DRAIN_WIDTH = 16;
    localparam int unsigned SUM_WIDTH   = LOAD_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        DRAIN,
        REPORT
    } state_e;

    state_e                  state_q, state_d;
    logic [TICK_WIDTH-1:0]   ticks_q, ticks_d;
    logic [LOAD_WIDTH-1:0]   tg_load_q, tg_load_d;
    logic [LOAD_WIDTH-1:0]   step_load_q, step_load_d;
    logic [CYC_WIDTH-1:0]    step_cycles_q, step_cycles_d;
    logic [DRAIN_WIDTH-1:0]  drain_cnt_q, drain_cnt_d;
    logic                    tg_start_q, tg_start_d;
    logic                    busy_q, busy_d;
    logic                    step_valid_q, step_valid_d;
    logic                    sweep_done_q, sweep_done_d;
    logic                    error_q, error_d;

    logic [SUM_WIDTH-1:0]    next_sum;
    logic                    sweep_end;
    logic [CYC_WIDTH-1:0]    cyc_inc;
    logic                    timeout_hit;

    // Next-load candidate and end-of-sweep decision; the extra sum bit catches carry out.
    always_comb begin
        next_sum  = SUM_WIDTH'(tg_load_q) + SUM_WIDTH'(load_step);
        sweep_end = (load_step == '0) || next_sum[LOAD_WIDTH]
                    || (next_sum[LOAD_WIDTH-1:0] > load_max);
        cyc_inc   = (step_cycles_q == '1) ? step_cycles_q : step_cycles_q + CYC_WIDTH'(1);
    end

`ifdef TG_RUN_CTRL_TIMEOUT_EN
    assign timeout_hit = (cyc_inc >= timeout_cycles);
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign timeout_hit    = 1'b0;
`endif

    // Next-state and output decode; registered outputs follow the next state.
    always_comb begin
        state_d       = state_q;
        ticks_d       = ticks_q + TICK_WIDTH'(1);
        tg_load_d     = tg_load_q;
        step_load_d   = step_load_q;
        step_cycles_d = step_cycles_q;
        drain_cnt_d   = drain_cnt_q;
        error_d       = error_q;
        sweep_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    tg_load_d = load_start;
                    error_d   = 1'b0;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                step_cycles_d = '0;
                state_d       = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                step_cycles_d = cyc_inc;
                if (timeout_hit) begin
                    error_d      = 1'b1;
                    sweep_done_d = 1'b1;
                    state_d      = IDLE;
                end else if (tg_done == '0) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                step_cycles_d = cyc_inc;
                if (timeout_hit) begin
                    error_d      = 1'b1;
                    sweep_done_d = 1'b1;
                    state_d      = IDLE;
                end else if (tg_done == '1) begin
                    drain_cnt_d = DRAIN_WIDTH'(1);
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                // A drain_cycles of 0 still spends the single entry cycle here.
                if (drain_cnt_q >= drain_cycles) begin
                    step_load_d = tg_load_q;
                    state_d     = REPORT;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_WIDTH'(1);
                end
            end
            REPORT: begin
                if (sweep_end) begin
                    sweep_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    tg_load_d = next_sum[LOAD_WIDTH-1:0];
                    state_d   = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase

        tg_start_d   = (state_d == LAUNCH);
        step_valid_d = (state_d == REPORT);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ticks_q       <= '0;
            tg_load_q     <= '0;
            step_load_q   <= '0;
            step_cycles_q <= '0;
            drain_cnt_q   <= '0;
            tg_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            step_valid_q  <= 1'b0;
            sweep_done_q  <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ticks_q       <= ticks_d;
            tg_load_q     <= tg_load_d;
            step_load_q   <= step_load_d;
            step_cycles_q <= step_cycles_d;
            drain_cnt_q   <= drain_cnt_d;
            tg_start_q    <= tg_start_d;
            busy_q        <= busy_d;
            step_valid_q  <= step_valid_d;
            sweep_done_q  <= sweep_done_d;
            error_q       <= error_d;
        end
    end

    assign tg_start    = tg_start_q;
    assign tg_load     = tg_load_q;
    assign ticks       = ticks_q;
    assign busy        = busy_q;
    assign step_valid  = step_valid_q;
    assign step_load   = step_load_q;
    assign step_cycles = step_cycles_q;
    assign sweep_done  = sweep_done_q;
    assign error       = error_q;

endmodule
